// File: rtl/spi_master_flash.sv
// spi_master_flash: single-lane SPI NOR flash framer (cmd/addr/dummy/data); define SPI_FL_DUMMY_EN for the dummy phase
module spi_master_flash #(
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ss,
  output logic        sclk,
  output logic        mosi_dq0,
  input  logic        miso_dq1,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic [23:0] address,
  input  logic [7:0]  command,
  input  logic [2:0]  commtype,
  input  logic [6:0]  ndata_bits,
  input  logic [9:0]  frame_struct,
  input  logic [3:0]  dummy_cycles,
  input  logic        validflag,
  output logic        validflag_out,
  output logic        tready
);
  typedef enum logic [3:0] {IDLE, SETUP, CMD, ADDR, DUMMY, WDATA, RDATA, HOLD, DONE} state_t;
  state_t state, nxt, data_st, dnxt;
  logic [71:0] tx, tx_init;
  logic [31:0] rx, dl;
  logic [5:0] cnt, a_len, n_eff, d_len, nlen, in_a, in_n;
  logic rd, in_rd, in_wr, ph, unused;
  assign unused = ^{frame_struct[8:0], dummy_cycles};
`ifdef SPI_FL_DUMMY_EN
  logic [5:0] in_d;
  assign in_d = commtype == 3'b101 ? {2'b00, dummy_cycles} : 6'd0;
`else
  assign d_len = 6'd0;
`endif
  // Decode the request and pre-pack every outgoing bit MSB-first so mosi is always tx[71]
  always_comb begin
    in_a = (commtype == 3'b001 || commtype == 3'b011 || commtype == 3'b101) ? (frame_struct[9] ? 6'd32 : 6'd24) : 6'd0;
    in_wr = commtype == 3'b010 || commtype == 3'b011;
    in_rd = commtype == 3'b100 || commtype == 3'b101;
    in_n = !(in_wr || in_rd) ? 6'd0 : ndata_bits > 7'd32 ? 6'd32 : ndata_bits[5:0];
    dl = data_in << (6'd32 - in_n);
    tx_init = {command, (in_a == 6'd32 ? {8'h00, address, 32'h0} : in_a == 6'd24 ? {address, 40'h0} : 64'h0) | (in_wr ? {dl, 32'h0} >> in_a : 64'h0)};
    data_st = n_eff == 6'd0 ? HOLD : rd ? RDATA : WDATA;
    dnxt = d_len != 6'd0 ? DUMMY : data_st;
    nxt = state == CMD ? (a_len != 6'd0 ? ADDR : dnxt) : state == ADDR ? dnxt : state == DUMMY ? data_st : HOLD;
    nlen = nxt == ADDR ? a_len : nxt == DUMMY ? d_len : n_eff;
  end
  // Frame sequencer: every bit is a leading half then a trailing half of sclk
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      ss <= 1'b1;
      sclk <= CPOL;
      mosi_dq0 <= 1'b0;
      data_out <= '0;
      validflag_out <= 1'b0;
      tready <= 1'b1;
      ph <= 1'b0;
      cnt <= '0;
      tx <= '0;
      rx <= '0;
      a_len <= '0;
      n_eff <= '0;
      rd <= 1'b0;
`ifdef SPI_FL_DUMMY_EN
      d_len <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (validflag) begin
          state <= SETUP;
          ss <= 1'b0;
          tready <= 1'b0;
          tx <= tx_init;
          rx <= '0;
          cnt <= 6'd8;
          ph <= 1'b0;
          a_len <= in_a;
          n_eff <= in_n;
          rd <= in_rd;
`ifdef SPI_FL_DUMMY_EN
          d_len <= in_d;
`endif
          mosi_dq0 <= CPHA ? 1'b0 : command[7];
        end
        SETUP: begin
          state <= CMD;
          sclk <= ~CPOL;
          if (CPHA) begin
            mosi_dq0 <= tx[71];
            tx <= tx << 1;
          end
        end
        HOLD: begin
          state <= DONE;
          ss <= 1'b1;
          validflag_out <= 1'b1;
          mosi_dq0 <= 1'b0;
          if (rd) data_out <= rx;
        end
        DONE: begin
          state <= IDLE;
          validflag_out <= 1'b0;
          tready <= 1'b1;
        end
        default: if (!ph) begin
          ph <= 1'b1;
          sclk <= CPOL;
          if (!CPHA) begin
            mosi_dq0 <= tx[70];
            tx <= tx << 1;
          end
          if (!CPHA && state == RDATA) rx <= {rx[30:0], miso_dq1};
        end else begin
          ph <= 1'b0;
          if (CPHA && state == RDATA) rx <= {rx[30:0], miso_dq1};
          if (cnt == 6'd1) begin
            state <= nxt;
            cnt <= nlen;
          end else cnt <= cnt - 6'd1;
          if (cnt == 6'd1 && nxt == HOLD) mosi_dq0 <= 1'b0;
          else begin
            sclk <= ~CPOL;
            if (CPHA) begin
              mosi_dq0 <= tx[71];
              tx <= tx << 1;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_flash.sv
// tb_spi_master_flash: directed checks of a mode-0 and a mode-3 master against a flash slave model
module tb_spi_master_flash;
  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] data_in = '0;
  logic [23:0] address = '0;
  logic [7:0] command = '0;
  logic [2:0] commtype = '0;
  logic [6:0] ndata_bits = '0;
  logic [9:0] frame_struct = '0;
  logic [3:0] dummy_cycles = '0;
  logic vf[2] = '{1'b0, 1'b0};
  logic miso[2] = '{1'b0, 1'b0};
  logic ss[2], sclk[2], mosi[2], vo[2], trdy[2];
  logic [31:0] dout[2];
  logic [79:0] cap[2];
  int ncap[2], pulses[2], sslow[2], vcnt[2];
  int vtot[2] = '{0, 0};
  int ftot[2] = '{0, 0};
  logic psclk[2] = '{1'b0, 1'b1};
  logic pss[2] = '{1'b1, 1'b1};
  int rstart = 0, rbits = 0;
  logic [31:0] rdata = '0;
  int checks = 0, errors = 0;
`ifdef SPI_FL_DUMMY_EN
  localparam int FR_START = 40;
  localparam int FR_SS = 146;
  localparam logic [79:0] FR_CAP = 80'h0B000100_0000000000;
`else
  localparam int FR_START = 32;
  localparam int FR_SS = 130;
  localparam logic [79:0] FR_CAP = 80'h0B000100_00000000;
`endif

  always #5 clk = ~clk;

  spi_master_flash #(.CPOL(1'b0), .CPHA(1'b0)) u0 (
    .clk(clk), .rst(rst), .ss(ss[0]), .sclk(sclk[0]), .mosi_dq0(mosi[0]), .miso_dq1(miso[0]),
    .data_in(data_in), .data_out(dout[0]), .address(address), .command(command), .commtype(commtype),
    .ndata_bits(ndata_bits), .frame_struct(frame_struct), .dummy_cycles(dummy_cycles),
    .validflag(vf[0]), .validflag_out(vo[0]), .tready(trdy[0]));
  spi_master_flash #(.CPOL(1'b1), .CPHA(1'b1)) u1 (
    .clk(clk), .rst(rst), .ss(ss[1]), .sclk(sclk[1]), .mosi_dq0(mosi[1]), .miso_dq1(miso[1]),
    .data_in(data_in), .data_out(dout[1]), .address(address), .command(command), .commtype(commtype),
    .ndata_bits(ndata_bits), .frame_struct(frame_struct), .dummy_cycles(dummy_cycles),
    .validflag(vf[1]), .validflag_out(vo[1]), .tready(trdy[1]));

  function automatic logic bitv(input int p);
    return (p >= rstart && p < rstart + rbits) ? rdata[5'(rbits - 1 - p + rstart)] : 1'b0;
  endfunction

  // Flash slave model: instance 0 is mode 0, instance 1 is mode 3
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (pss[g] === 1'b1 && ss[g] === 1'b0) begin
        ftot[g] += 1;
        cap[g] = '0;
        ncap[g] = 0;
        pulses[g] = 0;
        sslow[g] = 0;
        vcnt[g] = 0;
        if (g == 0) miso[g] = bitv(0);
      end
      if (ss[g] === 1'b0) sslow[g] += 1;
      if (vo[g] === 1'b1) begin
        vcnt[g] += 1;
        vtot[g] += 1;
      end
      if (ss[g] === 1'b0 && sclk[g] !== psclk[g]) begin
        if (psclk[g] == g[0]) begin
          if (g == 0) begin
            cap[g] = {cap[g][78:0], mosi[g]};
            ncap[g] += 1;
          end else miso[g] = bitv(pulses[g]);
          pulses[g] += 1;
        end else begin
          if (g == 0) miso[g] = bitv(pulses[g]);
          else begin
            cap[g] = {cap[g][78:0], mosi[g]};
            ncap[g] += 1;
          end
        end
      end
      psclk[g] = sclk[g];
      pss[g] = ss[g];
    end
  end

  task automatic setf(input logic [7:0] c, input logic [2:0] t, input logic [23:0] a, input logic [9:0] f,
                      input logic [31:0] d, input logic [6:0] n, input logic [3:0] dc);
    command = c; commtype = t; address = a; frame_struct = f; data_in = d; ndata_bits = n; dummy_cycles = dc;
  endtask

  task automatic run(input int g);
    @(posedge clk); #1 vf[g] = 1'b1;
    @(posedge clk); #1 vf[g] = 1'b0;
    for (int i = 0; i < 400 && trdy[g] !== 1'b1; i++) @(negedge clk);
    checks++;
    if (trdy[g] !== 1'b1) begin errors++; $display("FAIL run_timeout inst %0d tready=%b expected 1", g, trdy[g]); end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checks += 6;
      if (ss[g] !== 1'b1) begin errors++; $display("FAIL reset_ss inst %0d got %b expected 1", g, ss[g]); end
      if (sclk[g] !== g[0]) begin errors++; $display("FAIL reset_sclk inst %0d got %b expected %b", g, sclk[g], g[0]); end
      if (mosi[g] !== 1'b0) begin errors++; $display("FAIL reset_mosi inst %0d got %b expected 0", g, mosi[g]); end
      if (dout[g] !== 32'h0) begin errors++; $display("FAIL reset_dout inst %0d got %h expected 0", g, dout[g]); end
      if (vo[g] !== 1'b0) begin errors++; $display("FAIL reset_vo inst %0d got %b expected 0", g, vo[g]); end
      if (trdy[g] !== 1'b1) begin errors++; $display("FAIL reset_tready inst %0d got %b expected 1", g, trdy[g]); end
    end
  endtask

  task automatic test_read();
    setf(8'h5A, 3'b100, 24'h0, 10'h0, 32'h0, 7'd8, 4'd0);
    rstart = 8; rbits = 8; rdata = 32'hA3;
    for (int g = 0; g < 2; g++) begin
      run(g);
      checks += 6;
      if (cap[g] !== 80'h5A00) begin errors++; $display("FAIL read_mosi inst %0d got %h expected 5a00", g, cap[g]); end
      if (pulses[g] !== 16) begin errors++; $display("FAIL read_pulses inst %0d got %0d expected 16", g, pulses[g]); end
      if (dout[g] !== 32'hA3) begin errors++; $display("FAIL read_dout inst %0d got %h expected a3", g, dout[g]); end
      if (vcnt[g] !== 1) begin errors++; $display("FAIL read_done inst %0d got %0d expected 1", g, vcnt[g]); end
      if (sslow[g] !== 34) begin errors++; $display("FAIL read_sslow inst %0d got %0d expected 34", g, sslow[g]); end
      if (sclk[g] !== g[0]) begin errors++; $display("FAIL read_sclk_idle inst %0d got %b expected %b", g, sclk[g], g[0]); end
    end
  endtask

  task automatic test_write();
    rbits = 0;
    setf(8'hA3, 3'b010, 24'h0, 10'h0, 32'h5A, 7'd8, 4'd0);
    run(0);
    checks += 4;
    if (cap[0] !== 80'hA35A) begin errors++; $display("FAIL write_mosi got %h expected a35a", cap[0]); end
    if (ncap[0] !== 16) begin errors++; $display("FAIL write_bits got %0d expected 16", ncap[0]); end
    if (dout[0] !== 32'hA3) begin errors++; $display("FAIL write_dout_kept got %h expected a3", dout[0]); end
    if (sslow[0] !== 34) begin errors++; $display("FAIL write_sslow got %0d expected 34", sslow[0]); end
    setf(8'h06, 3'b010, 24'h0, 10'h0, 32'hFFFFFABC, 7'd12, 4'd0);
    run(0);
    checks += 2;
    if (cap[0] !== 80'h06ABC) begin errors++; $display("FAIL write12_mosi got %h expected 06abc", cap[0]); end
    if (sslow[0] !== 42) begin errors++; $display("FAIL write12_sslow got %0d expected 42", sslow[0]); end
    setf(8'h02, 3'b011, 24'h123456, 10'h0, 32'hDEADBEEF, 7'd40, 4'd9);
    run(1);
    checks += 3;
    if (cap[1] !== 80'h02123456DEADBEEF) begin errors++; $display("FAIL write_clamp_mosi got %h expected 02123456deadbeef", cap[1]); end
    if (ncap[1] !== 64) begin errors++; $display("FAIL write_clamp_bits got %0d expected 64", ncap[1]); end
    if (sslow[1] !== 130) begin errors++; $display("FAIL write_clamp_sslow got %0d expected 130", sslow[1]); end
  endtask

  task automatic test_address();
    setf(8'h03, 3'b001, 24'h555555, 10'h0, 32'hFFFFFFFF, 7'd8, 4'd0);
    run(0);
    checks += 3;
    if (cap[0] !== 80'h03555555) begin errors++; $display("FAIL addr24_mosi got %h expected 03555555", cap[0]); end
    if (ncap[0] !== 32) begin errors++; $display("FAIL addr24_bits got %0d expected 32", ncap[0]); end
    if (sslow[0] !== 66) begin errors++; $display("FAIL addr24_sslow got %0d expected 66", sslow[0]); end
    setf(8'h03, 3'b001, 24'h555555, 10'h200, 32'h0, 7'd0, 4'd0);
    run(0);
    checks += 3;
    if (cap[0] !== 80'h0300555555) begin errors++; $display("FAIL addr32_mosi got %h expected 0300555555", cap[0]); end
    if (ncap[0] !== 40) begin errors++; $display("FAIL addr32_bits got %0d expected 40", ncap[0]); end
    if (sslow[0] !== 82) begin errors++; $display("FAIL addr32_sslow got %0d expected 82", sslow[0]); end
  endtask

  task automatic test_fast_read();
    setf(8'h0B, 3'b101, 24'h000100, 10'h0, 32'h0, 7'd32, 4'd8);
    rstart = FR_START; rbits = 32; rdata = 32'hDEADBEEF;
    run(0);
    checks += 4;
    if (dout[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL fast_dout got %h expected deadbeef", dout[0]); end
    if (sslow[0] !== FR_SS) begin errors++; $display("FAIL fast_sslow got %0d expected %0d", sslow[0], FR_SS); end
    if (cap[0] !== FR_CAP) begin errors++; $display("FAIL fast_mosi got %h expected %h", cap[0], FR_CAP); end
    if (ncap[0] !== FR_START + 32) begin errors++; $display("FAIL fast_bits got %0d expected %0d", ncap[0], FR_START + 32); end
    setf(8'h0B, 3'b101, 24'h000100, 10'h0, 32'h0, 7'd16, 4'd0);
    rstart = 32; rbits = 16; rdata = 32'h0000BEEF;
    run(1);
    checks += 2;
    if (dout[1] !== 32'h0000BEEF) begin errors++; $display("FAIL fast0_dout got %h expected 0000beef", dout[1]); end
    if (sslow[1] !== 98) begin errors++; $display("FAIL fast0_sslow got %0d expected 98", sslow[1]); end
  endtask

  task automatic test_busy();
    int v0, f0;
    rbits = 0;
    v0 = vtot[0]; f0 = ftot[0];
    setf(8'h9F, 3'b110, 24'h0, 10'h0, 32'hFF, 7'd8, 4'd0);
    @(posedge clk); #1 vf[0] = 1'b1;
    @(posedge clk); #1 vf[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 vf[0] = 1'b1; command = 8'h11;
    @(posedge clk); #1 vf[0] = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (vtot[0] - v0 !== 1) begin errors++; $display("FAIL busy_done_pulses got %0d expected 1", vtot[0] - v0); end
    if (ftot[0] - f0 !== 1) begin errors++; $display("FAIL busy_frames got %0d expected 1", ftot[0] - f0); end
    if (cap[0] !== 80'h9F) begin errors++; $display("FAIL busy_mosi got %h expected 9f", cap[0]); end
    if (sslow[0] !== 18) begin errors++; $display("FAIL busy_sslow got %0d expected 18", sslow[0]); end
  endtask

  task automatic test_reset_mid();
    int v1;
    setf(8'h5A, 3'b100, 24'h0, 10'h0, 32'h0, 7'd8, 4'd0);
    rstart = 8; rbits = 8; rdata = 32'h3C;
    v1 = vtot[1];
    @(posedge clk); #1 vf[1] = 1'b1;
    @(posedge clk); #1 vf[1] = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks += 6;
    if (ss[1] !== 1'b1) begin errors++; $display("FAIL rstmid_ss got %b expected 1", ss[1]); end
    if (sclk[1] !== 1'b1) begin errors++; $display("FAIL rstmid_sclk got %b expected 1", sclk[1]); end
    if (trdy[1] !== 1'b1) begin errors++; $display("FAIL rstmid_tready got %b expected 1", trdy[1]); end
    if (mosi[1] !== 1'b0) begin errors++; $display("FAIL rstmid_mosi got %b expected 0", mosi[1]); end
    if (dout[1] !== 32'h0) begin errors++; $display("FAIL rstmid_dout got %h expected 0", dout[1]); end
    if (vo[1] !== 1'b0) begin errors++; $display("FAIL rstmid_vo got %b expected 0", vo[1]); end
    @(posedge clk); #1 rst = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    checks++;
    if (vtot[1] !== v1) begin errors++; $display("FAIL rstmid_no_done got %0d expected %0d", vtot[1], v1); end
    rbits = 0;
    setf(8'hA3, 3'b010, 24'h0, 10'h0, 32'h5A, 7'd8, 4'd0);
    run(1);
    checks++;
    if (cap[1] !== 80'hA35A) begin errors++; $display("FAIL rstmid_recover got %h expected a35a", cap[1]); end
  endtask

  task automatic test_back_to_back();
    rbits = 0;
    setf(8'hA5, 3'b000, 24'h0, 10'h0, 32'h0, 7'd0, 4'd0);
    @(posedge clk); #1 vf[0] = 1'b1;
    @(posedge clk); #1 vf[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 setf(8'h3C, 3'b010, 24'h0, 10'h0, 32'h81, 7'd8, 4'd0);
    for (int i = 0; i < 400 && trdy[0] !== 1'b1; i++) @(negedge clk);
    checks += 2;
    if (trdy[0] !== 1'b1) begin errors++; $display("FAIL b2b_timeout tready=%b expected 1", trdy[0]); end
    if (cap[0] !== 80'hA5) begin errors++; $display("FAIL b2b_first_mosi got %h expected a5", cap[0]); end
    vf[0] = 1'b1;
    @(posedge clk); #1 vf[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (ss[0] !== 1'b0) begin errors++; $display("FAIL b2b_accept ss got %b expected 0", ss[0]); end
    for (int i = 0; i < 400 && trdy[0] !== 1'b1; i++) @(negedge clk);
    @(negedge clk);
    checks += 2;
    if (cap[0] !== 80'h3C81) begin errors++; $display("FAIL b2b_second_mosi got %h expected 3c81", cap[0]); end
    if (vcnt[0] !== 1) begin errors++; $display("FAIL b2b_done got %0d expected 1", vcnt[0]); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    @(posedge clk); #1 rst = 1'b1;
    test_read();
    test_write();
    test_address();
    test_fast_read();
    test_busy();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_master_flash.md
# spi_master_flash

Single-lane SPI master for serial NOR flash command framing. It accepts one fully described transaction per `validflag` pulse, serializes command, optional address, optional dummy cycles and optional write data on `mosi_dq0`, and captures optional read data from `miso_dq1`. It sits between a flash controller FSM and the flash pins, and reports completion with `validflag_out`/`tready`.

## Interface
- `CPOL`, default 0: SCLK idle level.
- `CPHA`, default 0: 0 = sample on leading edge, drive on trailing; 1 = drive on leading, sample on trailing.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `ss` out 1: chip select, active low.
- `sclk` out 1: SPI clock, clk/2.
- `mosi_dq0` out 1: serial data out, MSB first.
- `miso_dq1` in 1: serial data in, MSB first.
- `data_in` in 32: write data, right-aligned; sends `data_in[ndata_bits-1:0]`.
- `data_out` out 32: read data, right-aligned, upper bits zero.
- `address` in 24: flash address, sent MSB first.
- `command` in 8: opcode.
- `commtype` in 3: frame type (see Operation).
- `ndata_bits` in 7: data-phase length; 0 skips phase; values >32 clamp to 32.
- `frame_struct` in 10: bit 9 = 32-bit address phase (`{8'h00,address}`), else 24-bit; bits 8:0 reserved, ignored.
- `dummy_cycles` in 4: SCLK cycles between address and read data.
- `validflag` in 1: start request, single-cycle.
- `validflag_out` out 1: one-cycle done pulse.
- `tready` out 1: idle, ready for a request.

## Operation
- commtype: 000 cmd; 001 cmd+addr; 010 cmd+write; 011 cmd+addr+write; 100 cmd+read; 101 cmd+addr+dummy+read; 110/111 treated as 000.
- Dummy phase occurs only in 101.
- Request accepted when `validflag`=1 and `tready`=1; all inputs latched that edge; later input changes have no effect.
- `validflag` while busy is ignored, not queued.
- States: IDLE → SETUP → CMD → [ADDR] → [DUMMY] → [WDATA|RDATA] → HOLD → DONE → IDLE.
- `mosi_dq0` driven 0 during DUMMY, RDATA, and when idle.
- Read bits shift into a 32-bit register LSB-in.
- `data_out` updates only at DONE and holds until the next read completes; write/command frames leave it unchanged.
- Reset mid-transaction: abort; outputs take reset values on that edge; no `validflag_out`.
- Reset values: `ss`=1, `sclk`=CPOL, `mosi_dq0`=0, `data_out`=0, `validflag_out`=0, `tready`=1.

## Timing
- Acceptance edge N: `tready`=0 and `ss`=0 from N+1 (SETUP, 1 clk, sclk idle, first bit on mosi when CPHA=0).
- Each bit takes 2 clk: sclk leaves idle level for 1 clk, returns for 1 clk.
- CPHA=0: mosi changes on trailing edge; miso sampled on leading edge.
- CPHA=1: mosi changes on leading edge; miso sampled on trailing edge.
- Dummy phase: 2 clk per dummy cycle.
- HOLD: 1 clk, sclk at idle, `ss` still 0.
- DONE: `ss`=1, `validflag_out`=1 for exactly 1 clk, `data_out` valid.
- `tready`=1 on the next cycle.
- `ss` low duration = 2 + 2×(8 + A + D + ndata_bits) clk, where:
  - A = 0, 24 or 32 (address bits sent);
  - D = dummy_cycles (commtype 101 only).
- A new request may be accepted on the first cycle `tready`=1.

## Configuration
- `SPI_FL_DUMMY_EN` defined: DUMMY state and counter present; commtype 101 inserts `dummy_cycles` cycles.
- `SPI_FL_DUMMY_EN` undefined: DUMMY logic removed; `dummy_cycles` ignored; 101 behaves as cmd+addr+read.

## Test plan
- Read, CPOL=CPHA=1:
  - stimulus: `command`=0x5A, `commtype`=100, `ndata_bits`=8, miso drives 0xA3;
  - response: mosi 0x5A MSB first, 16 sclk pulses, `data_out`=0x000000A3, one `validflag_out`, `ss` low 34 clk.
- Write:
  - stimulus: `command`=0xA3, `commtype`=010, `data_in`=0x5A, `ndata_bits`=8;
  - response: mosi bits A3 then 5A, 16 sclk pulses, `data_out` unchanged.
- Address:
  - stimulus: `commtype`=001, `address`=0x555555, `frame_struct`=0;
  - response: 32 bits 0x03555555 for `command`=0x03;
  - with `frame_struct[9]`=1: 40 bits sent.
- Fast read with `SPI_FL_DUMMY_EN`:
  - stimulus: `command`=0x0B, `commtype`=101, `dummy_cycles`=8, `ndata_bits`=32, miso 0xDEADBEEF;
  - response: `data_out`=0xDEADBEEF, `ss` low 146 clk.
- Busy: `validflag` pulsed mid-transaction -> ignored, exactly one `validflag_out`.
- Reset: `rst`=0 mid-transaction -> next edge `ss`=1, `sclk`=CPOL, `tready`=1, no done pulse.
